// File: rtl/sram_port_arbiter.sv
// sram_port_arbiter: round-robin read/write arbiter for a single-port SRAM, with zero-fill
// after reset or flush and a one-entry hold buffer for stalled read responses.
module sram_port_arbiter #(
  parameter int ADDR_W = 9,
  parameter int DATA_W = 76,
  parameter int MASK_W = 4
) (
  input  logic              clock_i,
  input  logic              reset_i,
  input  logic              flush_i,
  output logic              init_done_o,
  input  logic              r_req_valid_i,
  output logic              r_req_ready_o,
  input  logic [ADDR_W-1:0] r_req_addr_i,
  output logic              r_resp_valid_o,
  input  logic              r_resp_ready_i,
  output logic [DATA_W-1:0] r_resp_data_o,
  input  logic              w_req_valid_i,
  output logic              w_req_ready_o,
  input  logic [ADDR_W-1:0] w_req_addr_i,
  input  logic [DATA_W-1:0] w_req_data_i,
  input  logic [MASK_W-1:0] w_req_mask_i,
  output logic              sram_en_o,
  output logic              sram_wmode_o,
  output logic [ADDR_W-1:0] sram_addr_o,
  output logic [MASK_W-1:0] sram_wmask_o,
  output logic [DATA_W-1:0] sram_wdata_o,
  input  logic [DATA_W-1:0] sram_rdata_i
);
  typedef enum logic [1:0] {INIT, RUN, DRAIN} state_e;
  state_e state_q, state_d;
  logic [ADDR_W-1:0] init_cnt_q, init_cnt_d;
  logic [DATA_W-1:0] hold_q, hold_d;
  logic p1_q, p1_d, hold_v_q, hold_v_d, last_rd_q, last_rd_d;
  logic init, run, r_ok, r_acc, w_acc, stall;
  always_comb begin
    init = state_q == INIT;
    run = state_q == RUN && !flush_i;
    r_ok = !hold_v_q && (!p1_q || r_resp_ready_i);
    // Each ready looks only at the other side's valid, never its own.
    r_req_ready_o = run && r_ok && (!w_req_valid_i || !last_rd_q);
    w_req_ready_o = run && (!r_ok || !r_req_valid_i || last_rd_q);
    r_acc = r_req_valid_i && r_req_ready_o;
    w_acc = w_req_valid_i && w_req_ready_o;
    init_done_o = state_q == RUN;
    r_resp_valid_o = p1_q || hold_v_q;
    r_resp_data_o = hold_v_q ? hold_q : sram_rdata_i;
    sram_en_o = !reset_i && (init || r_acc || w_acc);
    sram_wmode_o = init || w_acc;
    sram_addr_o = init ? init_cnt_q : r_acc ? r_req_addr_i : w_req_addr_i;
    sram_wmask_o = init ? '1 : w_req_mask_i;
    sram_wdata_o = init ? '0 : w_req_data_i;
    // Capture the macro output while it still holds the pre-write value.
    stall = p1_q && !r_resp_ready_i;
    p1_d = r_acc;
    hold_v_d = hold_v_q ? !r_resp_ready_i : stall;
    hold_d = stall ? sram_rdata_i : hold_q;
    last_rd_d = r_acc ? 1'b1 : w_acc ? 1'b0 : last_rd_q;
    init_cnt_d = init ? init_cnt_q + ADDR_W'(1) : '0;
    state_d = (init && &init_cnt_q) ? RUN :
              (state_q == RUN && flush_i) ? DRAIN :
              (state_q == DRAIN && !hold_v_d) ? INIT : state_q;
  end
  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      state_q <= INIT;
      init_cnt_q <= '0;
      hold_q <= '0;
      p1_q <= 1'b0;
      hold_v_q <= 1'b0;
      last_rd_q <= 1'b0;
    end else begin
      state_q <= state_d;
      init_cnt_q <= init_cnt_d;
      hold_q <= hold_d;
      p1_q <= p1_d;
      hold_v_q <= hold_v_d;
      last_rd_q <= last_rd_d;
    end
  end
endmodule

// File: tb/tb_sram_port_arbiter.sv
// tb_sram_port_arbiter: directed vectors against sram_port_arbiter driving a behavioural
// single-port SRAM model with a registered read address.
module tb_sram_port_arbiter;
  localparam int AW = 9, DW = 76, MW = 4, LW = DW / MW;
  logic clk = 1'b0, rst = 1'b1, flush = 1'b0;
  logic init_done, r_valid = 1'b0, r_ready, r_resp_valid, r_resp_ready = 1'b1;
  logic w_valid = 1'b0, w_ready, sram_en, sram_wmode;
  logic [AW-1:0] r_addr = '0, w_addr = '0, sram_addr;
  logic [MW-1:0] w_mask = '0, sram_wmask;
  logic [DW-1:0] w_data = '0, r_resp_data, sram_wdata, sram_rdata;
  logic [DW-1:0] mem [0:(1<<AW)-1];
  logic [AW-1:0] raddr_q = '0;
  int vecs = 0, errs = 0;
  always #5 clk = ~clk;
  sram_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MASK_W(MW)) dut (
    .clock_i(clk), .reset_i(rst), .flush_i(flush), .init_done_o(init_done),
    .r_req_valid_i(r_valid), .r_req_ready_o(r_ready), .r_req_addr_i(r_addr),
    .r_resp_valid_o(r_resp_valid), .r_resp_ready_i(r_resp_ready), .r_resp_data_o(r_resp_data),
    .w_req_valid_i(w_valid), .w_req_ready_o(w_ready), .w_req_addr_i(w_addr),
    .w_req_data_i(w_data), .w_req_mask_i(w_mask),
    .sram_en_o(sram_en), .sram_wmode_o(sram_wmode), .sram_addr_o(sram_addr),
    .sram_wmask_o(sram_wmask), .sram_wdata_o(sram_wdata), .sram_rdata_i(sram_rdata)
  );
  // Macro model: reads register the address, so rdata tracks later writes to it.
  always @(posedge clk)
    if (sram_en) begin
      if (sram_wmode) begin
        for (int l = 0; l < MW; l++)
          if (sram_wmask[l]) mem[sram_addr][l*LW +: LW] <= sram_wdata[l*LW +: LW];
      end else raddr_q <= sram_addr;
    end
  assign sram_rdata = mem[raddr_q];
  task automatic chk(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    vecs++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic wait_init(output int n);
    n = 0;
    while (!init_done && n < 1000) begin
      tick();
      n++;
    end
  endtask
  task automatic rd(input logic [AW-1:0] a, output logic [DW-1:0] d);
    int n = 0;
    r_valid = 1'b1;
    r_addr = a;
    #1;
    while (!r_ready && n < 50) begin
      tick();
      #1;
      n++;
    end
    chk("rd_accept", DW'(n < 50), DW'(1));
    tick();
    r_valid = 1'b0;
    #1;
    chk("rd_valid", DW'(r_resp_valid), DW'(1));
    d = r_resp_data;
  endtask
  task automatic wr(input logic [AW-1:0] a, input logic [DW-1:0] dat, input logic [MW-1:0] m);
    int n = 0;
    w_valid = 1'b1;
    w_addr = a;
    w_data = dat;
    w_mask = m;
    #1;
    while (!w_ready && n < 50) begin
      tick();
      #1;
      n++;
    end
    chk("wr_accept", DW'(n < 50), DW'(1));
    tick();
    w_valid = 1'b0;
  endtask
  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    logic [DW-1:0] d;
    logic [7:0] g;
    int bad, n;
    tick();
    tick();
    chk("rst_en", DW'(sram_en), DW'(0));
    chk("rst_done", DW'(init_done), DW'(0));
    chk("rst_rdy", DW'({r_ready, w_ready}), DW'(0));
    chk("rst_rvld", DW'(r_resp_valid), DW'(0));
    chk("rst_addr", DW'(sram_addr), DW'(0));
    chk("rst_rdata", r_resp_data, sram_rdata);
    rst = 1'b0;
    bad = 0;
    for (int i = 0; i < 512; i++) begin
      #1;
      if ({sram_en, sram_wmode, sram_addr, sram_wmask} !== {2'b11, 9'(i), 4'hF} || sram_wdata !== '0)
        bad++;
      if (i == 511) chk("init_done_511", DW'(init_done), DW'(0));
      tick();
    end
    chk("init_seq", DW'(bad), DW'(0));
    #1;
    chk("init_done_512", DW'(init_done), DW'(1));
    chk("rdy_512", DW'({r_ready, w_ready}), DW'(2'b11));
    rd(9'h1A5, d);
    chk("rd_1a5", d, '0);
    wr(9'd3, '1, 4'b0101);
    r_valid = 1'b1;
    r_addr = 9'd3;
    #1;
    chk("rd3_rdy", DW'(r_ready), DW'(1));
    chk("rd3_early", DW'(r_resp_valid), DW'(0));
    tick();
    r_valid = 1'b0;
    #1;
    chk("rd3_vld", DW'(r_resp_valid), DW'(1));
    chk("rd3_data", r_resp_data, {19'h0, 19'h7FFFF, 19'h0, 19'h7FFFF});
    tick();
    #1;
    chk("rd3_one", DW'(r_resp_valid), DW'(0));
    wr(9'd7, DW'(8'h55), 4'hF);
    r_valid = 1'b1;
    r_addr = 9'd20;
    w_valid = 1'b1;
    w_addr = 9'd21;
    w_data = '0;
    w_mask = 4'hF;
    g = '0;
    for (int i = 0; i < 4; i++) begin
      #1;
      g = {g[5:0], r_ready, w_ready};
      tick();
    end
    r_valid = 1'b0;
    w_valid = 1'b0;
    chk("contention", DW'(g), DW'(8'b10011001));
    tick();
    r_valid = 1'b1;
    r_addr = 9'd7;
    #1;
    chk("bp_rdy", DW'(r_ready), DW'(1));
    tick();
    r_resp_ready = 1'b0;
    w_valid = 1'b1;
    w_addr = 9'd7;
    w_data = DW'(8'hAA);
    w_mask = 4'hF;
    #1;
    chk("bp_d1", r_resp_data, DW'(8'h55));
    chk("bp_wr_rdy", DW'(w_ready), DW'(1));
    chk("bp_rrdy1", DW'(r_ready), DW'(0));
    tick();
    w_valid = 1'b0;
    for (int i = 2; i <= 3; i++) begin
      #1;
      chk("bp_hold", r_resp_data, DW'(8'h55));
      chk("bp_vld", DW'(r_resp_valid), DW'(1));
      chk("bp_rrdy", DW'(r_ready), DW'(0));
      tick();
    end
    r_resp_ready = 1'b1;
    #1;
    chk("bp_take", r_resp_data, DW'(8'h55));
    chk("bp_rrdy4", DW'(r_ready), DW'(0));
    tick();
    #1;
    chk("bp_rrdy5", DW'(r_ready), DW'(1));
    tick();
    r_valid = 1'b0;
    #1;
    chk("rd7_new", r_resp_data, DW'(8'hAA));
    tick();
    r_valid = 1'b1;
    r_addr = 9'd7;
    r_resp_ready = 1'b0;
    #1;
    chk("fl_rdy", DW'(r_ready), DW'(1));
    tick();
    r_valid = 1'b0;
    tick();
    flush = 1'b1;
    #1;
    chk("fl_rdys", DW'({r_ready, w_ready}), DW'(0));
    chk("fl_hold", r_resp_data, DW'(8'hAA));
    tick();
    flush = 1'b0;
    r_resp_ready = 1'b1;
    #1;
    chk("drain_rdys", DW'({r_ready, w_ready}), DW'(0));
    chk("drain_vld", DW'(r_resp_valid), DW'(1));
    tick();
    #1;
    chk("fl_init", DW'({sram_en, sram_wmode, sram_addr}), DW'({2'b11, 9'd0}));
    chk("fl_vld0", DW'(r_resp_valid), DW'(0));
    wait_init(n);
    chk("fl_len", DW'(n), DW'(512));
    rd(9'd7, d);
    chk("fl_rd7", d, '0);
    rd(9'd3, d);
    chk("fl_rd3", d, '0);
    wr(9'd3, '1, 4'hF);
    r_valid = 1'b1;
    r_addr = 9'd3;
    #1;
    tick();
    r_valid = 1'b0;
    #1;
    chk("rr_vld", DW'(r_resp_valid), DW'(1));
    chk("rr_data", r_resp_data, '1);
    rst = 1'b1;
    #1;
    chk("rr_drop", DW'(r_resp_valid), DW'(0));
    chk("rr_en", DW'(sram_en), DW'(0));
    chk("rr_done", DW'(init_done), DW'(0));
    tick();
    rst = 1'b0;
    #1;
    chk("rr_init", DW'({sram_en, sram_wmode, sram_addr}), DW'({2'b11, 9'd0}));
    wait_init(n);
    chk("rr_len", DW'(n), DW'(512));
    rd(9'd3, d);
    chk("rr_rd3", d, '0);
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule

// File: doc/sram_port_arbiter.md
# sram_port_arbiter

Controller for one single-port synchronous SRAM macro (one `RW0` port, 1-cycle registered read, per-lane write mask). It shares the macro between a read requester and a write requester using ready/valid handshakes with round-robin arbitration. It zero-initialises the array after reset and on `flush`, and buffers read responses so that response back-pressure never loses data. It sits between a cache/predictor pipeline and its `*_ext` array.

## Interface
- `ADDR_W`, 9: SRAM address width; depth = 2^ADDR_W.
- `DATA_W`, 76: SRAM word width.
- `MASK_W`, 4: write-mask lanes; DATA_W divisible by MASK_W.

- `clock` in 1: single clock; all state updates on rising edge.
- `reset` in 1: asynchronous, active-high.
- `flush` in 1: request re-initialisation of whole array.
- `init_done` out 1: high when in RUN.
- `r_req_valid` in 1, `r_req_ready` out 1, `r_req_addr` in ADDR_W: read request.
- `r_resp_valid` out 1, `r_resp_ready` in 1, `r_resp_data` out DATA_W: read response.
- `w_req_valid` in 1, `w_req_ready` out 1, `w_req_addr` in ADDR_W, `w_req_data` in DATA_W, `w_req_mask` in MASK_W: write request.
- `sram_en`, `sram_wmode` out 1; `sram_addr` out ADDR_W; `sram_wmask` out MASK_W; `sram_wdata` out DATA_W: to macro `RW0_*`.
- `sram_rdata` in DATA_W: from macro; valid the cycle after a read enable, and combinationally follows later writes to that address.

## Operation
- States: INIT, RUN, DRAIN. Reset state is INIT with `init_cnt`=0.
- **INIT:**
  - Each cycle drives `sram_en`=1, `sram_wmode`=1, `sram_addr`=`init_cnt`, all-ones mask and zero data.
  - `init_cnt`++. When `init_cnt`=2^ADDR_W−1 is written, go to RUN.
  - Both request readies are 0.
  - `flush` is ignored.
- **RUN arbitration:**
  - `r_ok` = !`hold_v` && (!`p1` || `r_resp_ready`).
  - `w_ok` = 1.
  - If both requesters are valid and eligible, the grant goes to the side that did not win the previous grant (`last_rd` bit, reset 0 so read wins first).
  - A sole eligible valid requester is granted.
  - Ready is asserted only to the granted side, or to a sole eligible side regardless of its own valid. Ready never depends combinationally on the same side's valid.
  - `last_rd` updates only on an accepted request.
- **Macro drive:**
  - On an accepted read: `sram_en`=1, `wmode`=0, `addr`=`r_req_addr`; `p1` is set next cycle.
  - On an accepted write: `sram_en`=1, `wmode`=1, addr/data/mask passed through.
  - Otherwise `sram_en`=0.
- **Response path:**
  - `r_resp_valid` = `p1` | `hold_v`.
  - `r_resp_data` = `hold_v` ? `hold` : `sram_rdata`.
  - If `p1` && !`r_resp_ready`: `hold` <= `sram_rdata`, `hold_v` <= 1. The captured data is pre-write, so a write in that cycle or any later cycle to the same address cannot corrupt it.
  - `hold_v` clears on `r_resp_ready`.
  - Responses are delivered in request order; there is never more than one outstanding.
- **flush in RUN:**
  - The flush cycle and all later cycles drive both readies to 0.
  - Go to DRAIN; DRAIN goes to INIT (`init_cnt`=0) in the first cycle where `p1`=0 and `hold_v`=0.
  - A request accepted in the same cycle as `flush` is not possible, because readies are already 0.
- Reset asserted at any time (mid-INIT or mid-read) immediately returns to INIT with `p1`=`hold_v`=0. Any response is dropped.
- `sram_en` is forced to 0 while `reset` is high.

## Timing
- **Reset values:**
  - `init_done`, `r_req_ready`, `w_req_ready`, `r_resp_valid`, `sram_en` = 0.
  - `sram_addr` = 0.
  - `r_resp_data` = `sram_rdata`.
- **INIT length:** exactly 2^ADDR_W cycles (512 by default) after reset deassertion. `init_done` rises, and requests can be accepted, in cycle 2^ADDR_W.
- **Read latency:** request accepted in cycle t gives `r_resp_valid` in cycle t+1.
- **Throughput:** back-to-back reads at 1/cycle while `r_resp_ready`=1.
- **Back-pressure:** if `r_resp_ready`=0 in t+1, data is held from t+2 onward and no new read is accepted until the response is taken.
- **Writes:** take effect at the edge ending the accept cycle; a read accepted in t+1 returns the new data.
- **Flush:** DRAIN takes at most 1 cycle plus the time the response stalls. INIT then takes another 2^ADDR_W cycles.

## Test plan
- **Reset/init:**
  - Stimulus: deassert reset, no requests.
  - Required: `sram_en`=`wmode`=1 for cycles 0..511 with addr 0..511, mask 0xF, data 0; `init_done`=1 and readies live in cycle 512.
  - Afterwards, reading addr 0x1A5 returns 0.
- **Masked write then read:**
  - Stimulus: write addr 3, mask 0b0101, data all-ones; then read addr 3.
  - Required: response has lanes 0 and 2 all-ones and lanes 1 and 3 zero, valid exactly 1 cycle after read accept.
- **Contention:** both requesters hold valid for 4 cycles. Required grant order is R, W, R, W.
- **Response back-pressure:**
  - Stimulus: read addr 7 (value 0x55), hold `r_resp_ready`=0 for 3 cycles, meanwhile write 0xAA to addr 7.
  - Required: `r_resp_data`=0x55 stable throughout, and `r_req_ready`=0 until the response is taken.
- **Flush with pending response:**
  - Stimulus: `flush` asserted while `hold_v`=1.
  - Required: readies drop that cycle; INIT starts the cycle after the response handshake; `init_done` returns 512 cycles later; any prior write reads back 0.
- **Async reset mid-read:**
  - Stimulus: assert reset in the cycle `p1`=1.
  - Required: `r_resp_valid`=0 immediately, and full INIT is repeated.
